case_resp_driver: RTL and testbench

//  Initiator for the case-response handshake. Steps a code bus through
//  0..NUM_STEPS-1 and holds each code for a fixed settle window.

---
 rtl/case_resp_pkg.sv | 26 ++
 rtl/case_resp_timer.sv | 27 ++
 rtl/case_resp_driver.sv | 161 ++++++++++++++++
 tb/tb_case_resp_driver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/case_resp_pkg.sv
// Shared definitions for the case-response driver and its matching responder model.
package case_resp_pkg;

  localparam int CODE_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_GAP    = 3'd4,
    ST_NEXT   = 3'd5,
    ST_TAIL   = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  function automatic int maxOf4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/case_resp_timer.sv
// Loadable down-counter with a zero flag, shared by the settle, gap and tail waits.
module case_resp_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/case_resp_driver.sv
// Case-response initiator: steps a code bus, waits for the responder to settle,
// compares its result and accumulates a pass/fail verdict with error bookkeeping.
module case_resp_driver
  import case_resp_pkg::*;
#(
  parameter int CODE_W    = CODE_W_DEF,
  parameter int NUM_STEPS = 3,
  parameter int SETTLE    = 5,
  parameter int GAP       = 1,
  parameter int TAIL      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CODE_W-1:0] resp,
  output logic [CODE_W-1:0] code,
  output logic              code_vld,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CODE_W-1:0] fail_step,
  output logic [CODE_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(maxOf4(NUM_STEPS, SETTLE, GAP, TAIL) + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] TAIL_LD   = CNT_W'((TAIL > 0) ? TAIL - 1 : 0);

  state_e            state_q;
  logic [CNT_W-1:0]  step_q;
  logic [CODE_W-1:0] code_q;
  logic              code_vld_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [CODE_W-1:0] fail_step_q;
  logic [CODE_W-1:0] err_cnt_q;

  logic              tmrLoad_d;
  logic [CNT_W-1:0]  tmrLoadVal_d;
  logic              tmrDec_d;
  logic              tmrZero;
  logic              lastStep;

  assign lastStep = (step_q == LAST_STEP);

  // One timer serves all waits; it is loaded on the cycle before each wait begins.
  always_comb begin
    tmrLoad_d    = 1'b0;
    tmrLoadVal_d = SETTLE_LD;
    tmrDec_d     = 1'b0;
    case (state_q)
      ST_DRIVE: begin
        tmrLoad_d    = 1'b1;
        tmrLoadVal_d = SETTLE_LD;
      end
      ST_CHECK: begin
        tmrLoad_d    = (GAP > 0);
        tmrLoadVal_d = GAP_LD;
      end
      ST_NEXT: begin
        tmrLoad_d    = lastStep;
        tmrLoadVal_d = TAIL_LD;
      end
      ST_SETTLE, ST_GAP, ST_TAIL: tmrDec_d = !tmrZero;
      default: ;
    endcase
  end

  case_resp_timer #(.W(CNT_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmrLoad_d),
    .load_val_i(tmrLoadVal_d),
    .dec_i     (tmrDec_d),
    .zero_o    (tmrZero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      code_q      <= '0;
      code_vld_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_step_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_DRIVE;
            step_q      <= '0;
            err_cnt_q   <= '0;
            fail_step_q <= '0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_DRIVE: begin
          code_q     <= CODE_W'(step_q);
          code_vld_q <= 1'b1;
          state_q    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tmrZero) state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          // X/Z on resp must register as a mismatch, hence the case inequality.
          if (resp !== code_q) begin
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CODE_W'(1);
            if (err_cnt_q == '0) fail_step_q <= code_q;
          end
          state_q <= (GAP > 0) ? ST_GAP : ST_NEXT;
        end
        ST_GAP: begin
          if (tmrZero) state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (lastStep) begin
            code_vld_q <= 1'b0;
            if (TAIL == 0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              pass_q  <= (err_cnt_q == '0);
            end else begin
              state_q <= ST_TAIL;
            end
          end else begin
            step_q  <= step_q + CNT_W'(1);
            state_q <= ST_DRIVE;
          end
        end
        ST_TAIL: begin
          if (tmrZero) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_cnt_q == '0);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign code      = code_q;
  assign code_vld  = code_vld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_step = fail_step_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_case_resp_driver.sv
// Self-checking bench: two driver instances against behavioural responders and a run-level verdict model.
module tb_case_resp_driver;

  logic clk;
  logic rst_n;
  logic startA, startB;
  logic [3:0] respA, respB;
  logic [3:0] codeA, codeB;
  logic vldA, vldB, busyA, busyB, doneA, doneB, passA, passB;
  logic [3:0] failA, failB, errA, errB;

  int checks;
  int failures;
  int which;
  int modeA, latA;
  logic [3:0] stuckA;
  int lastA, lastB;

  logic [3:0] pipeA [0:7];
  logic [3:0] pipeB;

  logic [3:0] obsCode, obsFail, obsErr;
  logic obsVld, obsBusy, obsDone, obsPass;

  case_resp_driver dut (
    .clk(clk), .rst_n(rst_n), .start(startA), .resp(respA),
    .code(codeA), .code_vld(vldA), .busy(busyA), .done(doneA),
    .pass(passA), .fail_step(failA), .err_cnt(errA)
  );

  case_resp_driver #(.NUM_STEPS(16), .GAP(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(startB), .resp(respB),
    .code(codeB), .code_vld(vldB), .busy(busyB), .done(doneB),
    .pass(passB), .fail_step(failB), .err_cnt(errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder A: code delayed by latA cycles, then optionally stuck or inverted.
  always @(posedge clk) begin
    pipeA[0] <= codeA;
    for (int i = 1; i < 8; i++) pipeA[i] <= pipeA[i-1];
  end

  always_comb begin
    respA = pipeA[latA-1];
    if (modeA == 1) respA = stuckA;
    else if (modeA == 2) respA = ~pipeA[latA-1];
  end

  always @(posedge clk) pipeB <= codeB;
  assign respB = ~pipeB;

  assign obsCode = (which == 1) ? codeB : codeA;
  assign obsVld  = (which == 1) ? vldB  : vldA;
  assign obsBusy = (which == 1) ? busyB : busyA;
  assign obsDone = (which == 1) ? doneB : doneA;
  assign obsPass = (which == 1) ? passB : passA;
  assign obsFail = (which == 1) ? failB : failA;
  assign obsErr  = (which == 1) ? errB  : errA;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setStart(input int w, input logic v);
    if (w == 1) startB = v;
    else startA = v;
  endtask

  // Verdict of a whole run, derived from what the responder presents at each sample point.
  function automatic void expectVerdict(input int nSteps, input int settle, input int mode,
                                        input int lat, input int stuck, input int prev,
                                        output int eErr, output int eFail, output int ePass);
    int src, r;
    eErr = 0;
    eFail = 0;
    for (int k = 0; k < nSteps; k++) begin
      if (lat <= settle) src = k;
      else src = (k == 0) ? prev : k - 1;
      if (mode == 1) r = stuck;
      else if (mode == 2) r = (~src) & 15;
      else r = src & 15;
      if (r != (k & 15)) begin
        if (eErr == 0) eFail = k & 15;
        if (eErr < 15) eErr++;
      end
    end
    ePass = (eErr == 0) ? 1 : 0;
  endfunction

  task automatic applyStimulus(input int w, input int midAt, input bit pulseAtDone);
    int nSteps, settle, gap, tail, per, runLen, cycles, vldCount;
    int eErr, eFail, ePass, mode, lat, prev;
    which = w;
    settle = 5;
    tail = 10;
    if (w == 1) begin
      nSteps = 16; gap = 0; mode = 2; lat = 1; prev = lastB;
    end else begin
      nSteps = 3; gap = 1; mode = modeA; lat = latA; prev = lastA;
    end
    per = settle + gap + 3;
    runLen = nSteps * per + tail;
    expectVerdict(nSteps, settle, mode, lat, int'(stuckA), prev, eErr, eFail, ePass);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    setStart(w, 1'b1);
    @(negedge clk);
    setStart(w, 1'b0);
    cycles = 0;
    vldCount = 0;
    checkOutput("startClearsDone", obsDone, 0);
    checkOutput("busyAfterStart", obsBusy, 1);
    while (!obsDone && cycles < runLen + 50) begin
      if (obsVld) vldCount++;
      setStart(w, (cycles == midAt) || (pulseAtDone && cycles == runLen - 1));
      @(negedge clk);
      cycles++;
    end
    setStart(w, 1'b0);
    checkOutput("runLength", cycles, runLen);
    checkOutput("codeVldCycles", vldCount, nSteps * per - 1);
    checkOutput("finalCode", obsCode, (nSteps - 1) & 15);
    checkOutput("vldLowAtDone", obsVld, 0);
    checkOutput("busyLowAtDone", obsBusy, 0);
    checkOutput("pass", obsPass, ePass);
    checkOutput("failStep", obsFail, eFail);
    checkOutput("errCnt", obsErr, eErr);
    if (pulseAtDone) begin
      @(negedge clk);
      checkOutput("doneHeldAfterLateStart", obsDone, 1);
      checkOutput("noRestartBusy", obsBusy, 0);
    end
    if (w == 1) lastB = nSteps - 1;
    else lastA = nSteps - 1;
  endtask

  initial begin
    bit found;
    checks = 0;
    failures = 0;
    which = 0;
    rst_n = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
    modeA = 0;
    latA = 3;
    stuckA = 4'h0;
    lastA = 0;
    lastB = 0;

    repeat (3) @(negedge clk);
    checkOutput("rstCode", codeA, 0);
    checkOutput("rstVld", vldA, 0);
    checkOutput("rstBusy", busyA, 0);
    checkOutput("rstDone", doneA, 0);
    checkOutput("rstPass", passA, 0);
    checkOutput("rstFail", failA, 0);
    checkOutput("rstErr", errA, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] ideal responder, latency 3");
    applyStimulus(0, -1, 1'b0);

    $display("[TB] responder stuck at 1");
    modeA = 1;
    stuckA = 4'h1;
    applyStimulus(0, -1, 1'b0);

    $display("[TB] responder latency 6 after fresh reset");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lastA = 0;
    lastB = 0;
    modeA = 0;
    latA = 6;
    repeat (10) @(negedge clk);
    applyStimulus(0, -1, 1'b0);

    $display("[TB] reset during settle of step 1");
    which = 0;
    modeA = 1;
    stuckA = 4'h7;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (codeA == 4'h1 && vldA) found = 1'b1;
    end
    checkOutput("reachStep1", found, 1);
    checkOutput("errBeforeReset", errA, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstCode", codeA, 0);
    checkOutput("asyncRstVld", vldA, 0);
    checkOutput("asyncRstBusy", busyA, 0);
    checkOutput("asyncRstErr", errA, 0);
    checkOutput("asyncRstDone", doneA, 0);
    @(negedge clk);
    rst_n = 1'b1;
    lastA = 0;
    lastB = 0;
    modeA = 0;
    latA = 3;
    repeat (10) @(negedge clk);
    applyStimulus(0, -1, 1'b0);

    $display("[TB] start pulses mid-run and on done-rising cycle");
    applyStimulus(0, 10, 1'b1);
    applyStimulus(0, -1, 1'b0);

    $display("[TB] sixteen steps, inverted responder");
    applyStimulus(1, -1, 1'b0);

    $display("[TB] randomized responder runs");
    for (int r = 0; r < 5; r++) begin
      modeA = $urandom_range(0, 2);
      latA = $urandom_range(1, 7);
      stuckA = 4'($urandom_range(0, 15));
      repeat (10) @(negedge clk);
      applyStimulus(0, int'($urandom_range(1, 30)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
